bus_rr_arbiter: RTL and testbench

//  Shares one register bus (bus_slave interface, out modport) between N_MASTERS requesters.

---
 rtl/bus_rr_arbiter_pkg.sv | 10 +
 rtl/bus_rr_arbiter_rr_pick.sv | 32 +++
 rtl/bus_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and widths for the round-robin register-bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_t;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int RD_LAT_W = 3;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first requester strictly after ptr_i,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_onehot_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          any_o
);

    always_comb begin
        int   j;
        logic found;
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        any_o        = |req_i;
        found        = 1'b0;
        j            = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found           = 1'b1;
                gnt_onehot_o[j] = 1'b1;
                gnt_idx_o       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one register bus between N_MASTERS requesters.
// bus_wdata_o drives the slave's data_i; bus_rdata_i is the slave's data_o.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_MASTERS-1:0]        m_req_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [N_MASTERS-1:0]        m_gnt_o,
    output logic [N_MASTERS-1:0]        m_ack_o,
    output logic [DATA_W-1:0]           m_rdata_o,
    output logic                        busy_o,
    output logic                        bus_wr_o,
    output logic                        bus_rd_o,
    output logic [ADDR_W-1:0]           bus_addr_o,
    output logic [DATA_W-1:0]           bus_wdata_o,
    input  logic [DATA_W-1:0]           bus_rdata_i
);

    localparam int PW = $clog2(N_MASTERS);

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [PW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic [RD_LAT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;

    logic [N_MASTERS-1:0] pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req_i        (m_req_i),
        .ptr_i        (ptr_q),
        .gnt_onehot_o (pick_gnt),
        .gnt_idx_o    (pick_idx),
        .any_o        (pick_any)
    );

    // Bus address/data double as the latched request; they hold their value between transactions.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    we_d    = m_we_i[pick_idx];
                    addr_d  = m_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d = m_wdata_i[int'(pick_idx)*DATA_W +: DATA_W];
                    wr_d    = m_we_i[pick_idx];
                    rd_d    = ~m_we_i[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                end else if (RD_LATENCY == 0) begin
                    rdata_d = bus_rdata_i;
                    state_d = ACK;
                end else begin
                    cnt_d   = RD_LAT_W'(RD_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus_rdata_i;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                ptr_d   = idx_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= PW'(N_MASTERS - 1);
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign m_gnt_o     = gnt_q;
    assign m_ack_o     = (state_q == ACK) ? gnt_q : '0;
    assign m_rdata_o   = rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign bus_wr_o    = wr_q;
    assign bus_rd_o    = rd_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed vectors on a 4-master/latency-3 instance, then
// random traffic on it and on a 16-master/latency-0 instance against a timeline model.
module tb_bus_rr_arbiter;

    localparam int NA = 4;
    localparam int LA = 3;
    localparam int NB = 16;
    localparam int LB = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [15:0]  req   [2];
    logic [15:0]  we    [2];
    logic [511:0] addr  [2];
    logic [511:0] wdata [2];

    logic [3:0]  aGnt, aAck;
    logic [31:0] aRdata, aBusAddr, aBusWdata, aBusRdata;
    logic        aBusy, aWr, aRd;
    logic [15:0] bGnt, bAck;
    logic [31:0] bRdata, bBusAddr, bBusWdata, bBusRdata;
    logic        bBusy, bWr, bRd;

    int nCompared;
    int nMismatched;

    bus_rr_arbiter #(.N_MASTERS(NA), .RD_LATENCY(LA)) dutA (
        .clk(clk), .rst_n(rst_n),
        .m_req_i(req[0][3:0]), .m_we_i(we[0][3:0]),
        .m_addr_i(addr[0][127:0]), .m_wdata_i(wdata[0][127:0]),
        .m_gnt_o(aGnt), .m_ack_o(aAck), .m_rdata_o(aRdata), .busy_o(aBusy),
        .bus_wr_o(aWr), .bus_rd_o(aRd), .bus_addr_o(aBusAddr),
        .bus_wdata_o(aBusWdata), .bus_rdata_i(aBusRdata)
    );

    bus_rr_arbiter #(.N_MASTERS(NB), .RD_LATENCY(LB)) dutB (
        .clk(clk), .rst_n(rst_n),
        .m_req_i(req[1]), .m_we_i(we[1]),
        .m_addr_i(addr[1]), .m_wdata_i(wdata[1]),
        .m_gnt_o(bGnt), .m_ack_o(bAck), .m_rdata_o(bRdata), .busy_o(bBusy),
        .bus_wr_o(bWr), .bus_rd_o(bRd), .bus_addr_o(bBusAddr),
        .bus_wdata_o(bBusWdata), .bus_rdata_i(bBusRdata)
    );

    function automatic logic [31:0] slaveData(input logic [31:0] a);
        if (a == 32'h20) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Slave for instance A: data valid only in the cycle exactly LA cycles after rd.
    logic        sAct;
    int          sRem;
    logic [31:0] sAddr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sAct  <= 1'b0;
            sRem  <= 0;
            sAddr <= '0;
        end else begin
            if (sAct) begin
                if (sRem == 0) sAct <= 1'b0;
                else           sRem <= sRem - 1;
            end
            if (aRd) begin
                sAct  <= 1'b1;
                sRem  <= LA - 1;
                sAddr <= aBusAddr;
            end
        end
    end

    always_comb begin
        aBusRdata = (sAct && sRem == 0) ? slaveData(sAddr) : ~slaveData(sAddr);
        bBusRdata = bRd ? slaveData(bBusAddr) : ~slaveData(bBusAddr);
    end

    function automatic int nOf(input int d);   return (d == 0) ? NA : NB; endfunction
    function automatic int latOf(input int d); return (d == 0) ? LA : LB; endfunction
    function automatic logic [15:0] gntOf(input int d); return (d == 0) ? {12'b0, aGnt} : bGnt; endfunction
    function automatic logic [15:0] ackOf(input int d); return (d == 0) ? {12'b0, aAck} : bAck; endfunction
    function automatic logic [31:0] rdataOf(input int d); return (d == 0) ? aRdata : bRdata; endfunction
    function automatic logic [2:0] strobesOf(input int d);
        return (d == 0) ? {aWr, aRd, aBusy} : {bWr, bRd, bBusy};
    endfunction
    function automatic logic [63:0] busOf(input int d);
        return (d == 0) ? {aBusAddr, aBusWdata} : {bBusAddr, bBusWdata};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setMaster(input int d, input int i, input logic w,
                             input logic [31:0] a, input logic [31:0] wd);
        we[d][i]              = w;
        addr[d][32*i +: 32]   = a;
        wdata[d][32*i +: 32]  = wd;
        req[d][i]             = 1'b1;
    endtask

    typedef struct {
        int          master;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          expLat;
        logic [31:0] expRdata;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] lastRdata;

    task automatic applyStimulus(input int idx, input vec_t v);
        int          k, wrCnt, rdCnt, strobeAt;
        logic        got;
        logic [3:0]  oh, ackV, gntV;
        logic [31:0] sa, sw, rdV;
        k = 0; wrCnt = 0; rdCnt = 0; strobeAt = 0; got = 1'b0;
        ackV = '0; gntV = '0; sa = '0; sw = '0; rdV = '0;
        oh = 4'b0001 << v.master;
        @(negedge clk);
        setMaster(0, v.master, v.we, v.addr, v.wdata);
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (aWr || aRd) begin
                strobeAt = k;
                sa = aBusAddr;
                sw = aBusWdata;
            end
            if (aWr) wrCnt++;
            if (aRd) rdCnt++;
            if (aAck != 4'b0) begin
                got  = 1'b1;
                ackV = aAck;
                gntV = aGnt;
                rdV  = aRdata;
            end
        end
        req[0][v.master] = 1'b0;
        checkOutput($sformatf("vec%0d.latency", idx), 64'(k), 64'(v.expLat));
        checkOutput($sformatf("vec%0d.ackGnt", idx), {gntV, ackV}, {oh, oh});
        checkOutput($sformatf("vec%0d.strobes", idx), {8'(wrCnt), 8'(rdCnt), 8'(strobeAt)},
                    {8'(v.we ? 1 : 0), 8'(v.we ? 0 : 1), 8'd1});
        checkOutput($sformatf("vec%0d.bus", idx), {sa, sw}, {v.addr, v.wdata});
        checkOutput($sformatf("vec%0d.rdata", idx), rdV, v.we ? lastRdata : v.expRdata);
        if (!v.we) lastRdata = v.expRdata;
        @(negedge clk);
        checkOutput($sformatf("vec%0d.idle", idx), {aGnt, aAck, aBusy}, '0);
    endtask

    // Reset with everyone requesting, then continuous contention among all four masters.
    task automatic resetAndContention();
        int         nAck, cycles;
        logic [3:0] oh;
        rst_n = 1'b0;
        for (int i = 0; i < NA; i++) setMaster(0, i, 1'b1, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i));
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs", {aGnt, aAck, aWr, aRd, aBusy}, '0);
        checkOutput("resetBus", {aBusAddr, aBusWdata}, '0);
        checkOutput("resetRdata", aRdata, '0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("firstGrant", aGnt, 4'b0001);
        nAck = 0; cycles = 0;
        while (nAck < 6 && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (aAck != 4'b0) begin
                oh = 4'b0001 << (nAck % NA);
                checkOutput($sformatf("contend%0d.ackGnt", nAck), {aAck, aGnt}, {oh, oh});
                nAck++;
                if (nAck == 6) req[0] = '0;
            end
        end
        checkOutput("contendCount", 64'(nAck), 64'd6);
        @(negedge clk);
        checkOutput("contendIdle", {aGnt, aBusy}, '0);
    endtask

    task automatic dropAndResetSeq();
        logic ackSeen;
        setMaster(0, 2, 1'b1, 32'h3C, 32'hCAFE_F00D);
        @(negedge clk);
        checkOutput("dropIssueStrobe", {aWr, aRd}, 2'b10);
        checkOutput("dropIssueBus", {aBusAddr, aBusWdata}, {32'h3C, 32'hCAFE_F00D});
        req[0][2] = 1'b0;
        @(negedge clk);
        checkOutput("dropAck", {aAck, aGnt}, {4'b0100, 4'b0100});
        @(negedge clk);
        checkOutput("dropIdle", {aAck, aGnt, aBusy}, '0);
        setMaster(0, 1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        checkOutput("waitIssueStrobe", {aWr, aRd}, 2'b01);
        @(negedge clk);
        checkOutput("waitStrobes", {aWr, aRd, aBusy}, 3'b001);
        rst_n = 1'b0;
        req[0] = '0;
        #1;
        checkOutput("midReset", {aGnt, aAck, aWr, aRd, aBusy}, '0);
        checkOutput("midResetRdata", aRdata, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ackSeen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (aAck != 4'b0 || aBusy) ackSeen = 1'b1;
        end
        checkOutput("noAckAfterReset", {63'b0, ackSeen}, '0);
    endtask

    // Timeline model: when free and someone requests, the next requester after the last
    // winner starts at cycle c; grant c+1..ack, strobe at c+1, ack at c+2(+latency on reads).
    int          cyc;
    int          freeAt   [2];
    int          ptrM     [2];
    logic        expAct   [2];
    int          expM     [2];
    int          expStart [2];
    int          expAckC  [2];
    logic        expWe    [2];
    logic [31:0] expAddr  [2];
    logic [31:0] expWd    [2];

    task automatic checkCycle(input int d);
        logic [15:0] gE, aE;
        logic        wE, rE, bE;
        gE = '0; aE = '0; wE = 1'b0; rE = 1'b0; bE = 1'b0;
        if (expAct[d]) begin
            if (cyc > expStart[d] && cyc <= expAckC[d]) begin
                gE = 16'b1 << expM[d];
                bE = 1'b1;
            end
            if (cyc == expStart[d] + 1) begin
                wE = expWe[d];
                rE = !expWe[d];
            end
            if (cyc == expAckC[d]) aE = 16'b1 << expM[d];
        end
        checkOutput($sformatf("rnd%0d.cyc%0d.ctrl", d, cyc),
                    {gntOf(d), ackOf(d), strobesOf(d)}, {gE, aE, wE, rE, bE});
        if (expAct[d] && cyc == expStart[d] + 1)
            checkOutput($sformatf("rnd%0d.cyc%0d.bus", d, cyc), busOf(d), {expAddr[d], expWd[d]});
        if (expAct[d] && cyc == expAckC[d]) begin
            if (!expWe[d])
                checkOutput($sformatf("rnd%0d.cyc%0d.rdata", d, cyc), rdataOf(d), slaveData(expAddr[d]));
            expAct[d] = 1'b0;
        end
    endtask

    task automatic driveMasters(input int d);
        logic [15:0] a;
        a = ackOf(d);
        for (int i = 0; i < nOf(d); i++) begin
            if (a[i]) begin
                if ($urandom % 2 == 0) req[d][i] = 1'b0;
                else setMaster(d, i, 1'($urandom % 2), $urandom, $urandom);
            end else if (!req[d][i] && ($urandom % 4 == 0)) begin
                setMaster(d, i, 1'($urandom % 2), $urandom, $urandom);
            end
        end
    endtask

    task automatic arbitrate(input int d);
        int n, j;
        n = nOf(d);
        if (cyc >= freeAt[d] && req[d] != '0) begin
            for (int k = 1; k <= n; k++) begin
                j = (ptrM[d] + k) % n;
                if (req[d][j] && cyc >= freeAt[d]) begin
                    expAct[d]   = 1'b1;
                    expM[d]     = j;
                    expWe[d]    = we[d][j];
                    expAddr[d]  = addr[d][32*j +: 32];
                    expWd[d]    = wdata[d][32*j +: 32];
                    expStart[d] = cyc;
                    expAckC[d]  = cyc + 2 + (we[d][j] ? 0 : latOf(d));
                    freeAt[d]   = expAckC[d] + 1;
                    ptrM[d]     = j;
                end
            end
        end
    endtask

    task automatic randomPhase();
        for (int d = 0; d < 2; d++) begin
            freeAt[d] = 0;
            ptrM[d]   = nOf(d) - 1;
            expAct[d] = 1'b0;
            req[d]    = '0;
        end
        for (cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checkCycle(d);
                driveMasters(d);
                arbitrate(d);
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        lastRdata   = '0;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        resetAndContention();

        vecs[0] = '{master: 0, we: 1'b1, addr: 32'h10,        wdata: 32'hDEAD_BEEF, expLat: 2, expRdata: 32'h0};
        vecs[1] = '{master: 1, we: 1'b0, addr: 32'h20,        wdata: 32'h0,         expLat: 5, expRdata: 32'h1234_5678};
        vecs[2] = '{master: 3, we: 1'b1, addr: 32'h44,        wdata: 32'h0BAD_F00D, expLat: 2, expRdata: 32'h0};
        vecs[3] = '{master: 2, we: 1'b0, addr: 32'h80,        wdata: 32'h1111_2222, expLat: 5, expRdata: slaveData(32'h80)};
        vecs[4] = '{master: 0, we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0,         expLat: 5, expRdata: slaveData(32'hFFFF_FFFC)};
        vecs[5] = '{master: 3, we: 1'b1, addr: 32'h0,         wdata: 32'hFFFF_FFFF, expLat: 2, expRdata: 32'h0};
        for (int v = 0; v < 6; v++) applyStimulus(v, vecs[v]);

        @(negedge clk);
        dropAndResetSeq();
        randomPhase();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
